// File: rtl/mem_rd_arbiter.sv
// Three-source read arbiter: round-robin grant into a single request register,
// per-source outstanding caps, and ID-tag routing of returned data beats.
module mem_rd_arbiter #(
  parameter int unsigned ADDR_W    = 40,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [2:0]          req_valid_i,
  output logic [2:0]          req_ready_o,
  input  logic [3*ADDR_W-1:0] req_addr_i,
  input  logic [3*LEN_W-1:0]  req_len_i,
  input  logic [3*ID_W-1:0]   req_id_i,
  output logic [2:0]          resp_valid_o,
  input  logic [2:0]          resp_ready_i,
  output logic [DATA_W-1:0]   resp_data_o,
  output logic [ID_W-1:0]     resp_id_o,
  output logic                resp_last_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [ADDR_W-1:0]   mem_req_addr_o,
  output logic [LEN_W-1:0]    mem_req_len_o,
  output logic [ID_W+1:0]     mem_req_id_o,
  input  logic                mem_resp_valid_i,
  output logic                mem_resp_ready_o,
  input  logic [DATA_W-1:0]   mem_resp_data_i,
  input  logic [ID_W+1:0]     mem_resp_id_i,
  input  logic                mem_resp_last_i,
  output logic                err_o
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned NSRC  = 3;

  typedef enum logic {EMPTY, FULL} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [ID_W+1:0]   id;
  } req_t;

  state_t           state_q, state_d;
  logic [1:0]       rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q [NSRC];
  logic [CNT_W-1:0] cnt_d [NSRC];
  req_t             req_q, sel_req;
  logic             err_q, err_d;

  logic [3:0] elig;
  logic [1:0] p0, p1, p2, gidx;
  logic       loadable, load;
  logic [3:0] grant;
  logic [1:0] src;
  logic       last_acc;

  // Eligibility and rotating-priority pick; bit 3 pads the vector so 2-bit indices stay in range
  always_comb begin
    elig = 4'b0000;
    for (int s = 0; s < NSRC; s++)
      elig[s] = req_valid_i[s] && (cnt_q[s] < CNT_W'(MAX_OUTST));
    case (rr_q)
      2'd1:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
      2'd2:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
      default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
    endcase
    if (elig[p0])      gidx = p0;
    else if (elig[p1]) gidx = p1;
    else               gidx = p2;
  end

  assign loadable    = (state_q == EMPTY) || mem_req_ready_i;
  assign grant       = 4'(load) << gidx;
  assign req_ready_o = grant[2:0];

  always_comb begin
    sel_req = '0;
    case (gidx)
      2'd0: begin
        sel_req.addr = req_addr_i[0 +: ADDR_W];
        sel_req.len  = req_len_i[0 +: LEN_W];
        sel_req.id   = {2'd0, req_id_i[0 +: ID_W]};
      end
      2'd1: begin
        sel_req.addr = req_addr_i[ADDR_W +: ADDR_W];
        sel_req.len  = req_len_i[LEN_W +: LEN_W];
        sel_req.id   = {2'd1, req_id_i[ID_W +: ID_W]};
      end
      default: begin
        sel_req.addr = req_addr_i[2*ADDR_W +: ADDR_W];
        sel_req.len  = req_len_i[2*LEN_W +: LEN_W];
        sel_req.id   = {2'd2, req_id_i[2*ID_W +: ID_W]};
      end
    endcase
  end

  // Request register FSM: next state, load strobe and RR pointer
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    load    = 1'b0;
    if (loadable) begin
      if (|elig) begin
        load    = 1'b1;
        state_d = FULL;
        rr_d    = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  // Response routing by source tag; tag 3 is sunk so the channel never stalls
  assign src              = mem_resp_id_i[ID_W+1:ID_W];
  assign mem_resp_ready_o = ({1'b1, resp_ready_i} >> src) & 4'b0001 ? 1'b1 : 1'b0;
  assign resp_valid_o     = 3'((4'(mem_resp_valid_i) << src) & 4'b0111);
  assign resp_data_o      = mem_resp_data_i;
  assign resp_id_o        = mem_resp_id_i[ID_W-1:0];
  assign resp_last_o      = mem_resp_last_i;
  assign last_acc         = mem_resp_valid_i && mem_resp_ready_o && mem_resp_last_i;

  always_comb begin
    err_d = err_q || (mem_resp_valid_i && (src == 2'd3));
    for (int s = 0; s < NSRC; s++) begin
      cnt_d[s] = cnt_q[s];
      if (last_acc && (src == 2'(s)) && (cnt_q[s] == '0)) begin
        err_d = 1'b1;
        if (grant[s]) cnt_d[s] = cnt_q[s] + CNT_W'(1);
      end else begin
        case ({grant[s], last_acc && (src == 2'(s))})
          2'b10:   cnt_d[s] = cnt_q[s] + CNT_W'(1);
          2'b01:   cnt_d[s] = cnt_q[s] - CNT_W'(1);
          default: cnt_d[s] = cnt_q[s];
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= EMPTY;
      rr_q    <= 2'd0;
      req_q   <= '0;
      err_q   <= 1'b0;
      for (int s = 0; s < NSRC; s++) cnt_q[s] <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
      if (load) req_q <= sel_req;
      for (int s = 0; s < NSRC; s++) cnt_q[s] <= cnt_d[s];
    end
  end

  assign mem_req_valid_o = (state_q == FULL);
  assign mem_req_addr_o  = req_q.addr;
  assign mem_req_len_o   = req_q.len;
  assign mem_req_id_o    = req_q.id;
  assign err_o           = err_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter: arbitration order, hold, caps, routing, errors, reset.
module tb_mem_rd_arbiter;

  localparam int unsigned ADDR_W = 40;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned DATA_W = 512;

  logic                clk = 1'b0;
  logic                rstn;
  logic [2:0]          req_valid, req_ready, resp_valid, resp_ready;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*LEN_W-1:0]  req_len;
  logic [3*ID_W-1:0]   req_id;
  logic [DATA_W-1:0]   resp_data, mem_resp_data;
  logic [ID_W-1:0]     resp_id;
  logic                resp_last, mem_req_valid, mem_req_ready;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic [LEN_W-1:0]    mem_req_len;
  logic [ID_W+1:0]     mem_req_id, mem_resp_id;
  logic                mem_resp_valid, mem_resp_ready, mem_resp_last, err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_rd_arbiter dut (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_len_i(req_len), .req_id_i(req_id),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_data_o(resp_data), .resp_id_o(resp_id), .resp_last_o(resp_last),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_req_addr_o(mem_req_addr), .mem_req_len_o(mem_req_len), .mem_req_id_o(mem_req_id),
    .mem_resp_valid_i(mem_resp_valid), .mem_resp_ready_o(mem_resp_ready),
    .mem_resp_data_i(mem_resp_data), .mem_resp_id_i(mem_resp_id),
    .mem_resp_last_i(mem_resp_last), .err_o(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                         input logic [ID_W-1:0] i);
    req_addr[s*ADDR_W +: ADDR_W] = a;
    req_len[s*LEN_W +: LEN_W]    = l;
    req_id[s*ID_W +: ID_W]       = i;
  endtask

  logic [4:0]  pat;
  int          b;
  logic [31:0] w;

  initial begin
    rstn = 1'b0; req_valid = '0; req_addr = '0; req_len = '0; req_id = '0;
    resp_ready = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_resp_data = '0; mem_resp_id = '0; mem_resp_last = 1'b0;
    #12;
    chk("rst_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_addr", 64'(mem_req_addr), 64'd0);
    chk("rst_len", 64'(mem_req_len), 64'd0);
    chk("rst_id", 64'(mem_req_id), 64'd0);
    tick();
    rstn = 1'b1;

    // round-robin with all three sources requesting every cycle
    for (int s = 0; s < 3; s++) set_src(s, 40'hA000 + 40'(s), 8'(s), 4'(s + 1));
    req_valid = 3'b111; mem_req_ready = 1'b1;
    #1 chk("rr_g0", 64'(req_ready), 64'b001);
    tick();
    chk("rr_id0", 64'(mem_req_id), 64'h01);
    chk("rr_addr0", 64'(mem_req_addr), 64'hA000);
    chk("rr_vld0", 64'(mem_req_valid), 64'd1);
    chk("rr_g1", 64'(req_ready), 64'b010);
    tick();
    chk("rr_id1", 64'(mem_req_id), 64'h12);
    chk("rr_g2", 64'(req_ready), 64'b100);
    tick();
    chk("rr_id2", 64'(mem_req_id), 64'h23);
    chk("rr_len2", 64'(mem_req_len), 64'd2);
    chk("rr_g3", 64'(req_ready), 64'b001);
    tick();
    chk("rr_id3", 64'(mem_req_id), 64'h01);
    chk("rr_ptr1", 64'(req_ready), 64'b010);

    // push source 2 to three outstanding, then reset while FULL
    req_valid = 3'b100;
    #1 chk("s2_g_a", 64'(req_ready), 64'b100);
    tick();
    chk("s2_g_b", 64'(req_ready), 64'b100);
    tick();
    req_valid = 3'b000; mem_req_ready = 1'b0;
    tick();
    chk("full_vld", 64'(mem_req_valid), 64'd1);
    chk("full_id", 64'(mem_req_id), 64'h23);
    #2 rstn = 1'b0;
    #1 chk("async_rst_vld", 64'(mem_req_valid), 64'd0);
    chk("async_rst_id", 64'(mem_req_id), 64'd0);
    tick();
    rstn = 1'b1;
    req_valid = 3'b111;
    #1 chk("post_rst_g0", 64'(req_ready), 64'b001);
    req_valid = 3'b000;

    // downstream stall holds the registered request stable
    set_src(1, 40'h1000, 8'd3, 4'd5);
    req_valid = 3'b010;
    #1 chk("hold_grant", 64'(req_ready), 64'b010);
    tick();
    req_valid = 3'b111;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("hold_vld", 64'(mem_req_valid), 64'd1);
      chk("hold_addr", 64'(mem_req_addr), 64'h1000);
      chk("hold_len", 64'(mem_req_len), 64'd3);
      chk("hold_id", 64'(mem_req_id), 64'h15);
      chk("hold_noready", 64'(req_ready), 64'b000);
      tick();
    end
    mem_req_ready = 1'b1;
    #1 chk("drain_refill", 64'(req_ready), 64'b100);
    req_valid = 3'b000;
    tick();
    chk("drain_empty", 64'(mem_req_valid), 64'd0);

    // source 2 outstanding cap (cnt: s0=0 s1=1 s2=0, rr=2)
    req_valid = 3'b100;
    for (int c = 0; c < 4; c++) begin
      #1 chk("cap_acc", 64'(req_ready), 64'b100);
      tick();
    end
    chk("cap_block", 64'(req_ready), 64'b000);
    req_valid = 3'b111;
    #1 chk("cap_s0", 64'(req_ready), 64'b001);
    tick();
    chk("cap_s1", 64'(req_ready), 64'b010);
    tick();
    chk("cap_skip2", 64'(req_ready), 64'b001);
    req_valid = 3'b100;
    #1 chk("cap_block2", 64'(req_ready), 64'b000);
    mem_resp_valid = 1'b1; mem_resp_id = 6'b10_0111; mem_resp_last = 1'b1; resp_ready = 3'b100;
    #1 chk("s2_resp_vld", 64'(resp_valid), 64'b100);
    chk("s2_resp_rdy", 64'(mem_resp_ready), 64'd1);
    tick();
    mem_resp_valid = 1'b0; mem_resp_last = 1'b0; resp_ready = 3'b000;
    #1 chk("cap_release", 64'(req_ready), 64'b100);
    req_valid = 3'b000;
    tick();

    // 4-beat burst to source 0 with ready toggling (s0 has one outstanding)
    pat = 5'b11101;
    b = 0;
    mem_resp_id = 6'b00_0011;
    for (int c = 0; c < 5; c++) begin
      w = 32'hD000_0000 | 32'(b);
      mem_resp_valid = 1'b1;
      mem_resp_data  = {16{w}};
      mem_resp_last  = (b == 3);
      resp_ready     = {2'b00, pat[c]};
      #1;
      chk("burst_vld", 64'(resp_valid), 64'b001);
      chk("burst_id", 64'(resp_id), 64'd3);
      chk("burst_rdy", 64'(mem_resp_ready), 64'(pat[c]));
      chk("burst_last", 64'(resp_last), 64'(b == 3));
      chk("burst_data", resp_data[63:0], {w, w});
      tick();
      if (pat[c]) b++;
    end
    mem_resp_valid = 1'b0; mem_resp_last = 1'b0; resp_ready = 3'b000;
    chk("burst_beats", 64'(b), 64'd4);
    chk("burst_noerr", 64'(err), 64'd0);

    // extra last beat for source 0 now at zero outstanding
    mem_resp_valid = 1'b1; mem_resp_last = 1'b1; resp_ready = 3'b001;
    #1 chk("zero_deliv", 64'(resp_valid), 64'b001);
    tick();
    mem_resp_valid = 1'b0; mem_resp_last = 1'b0;
    chk("zero_err", 64'(err), 64'd1);
    tick();
    chk("zero_sticky", 64'(err), 64'd1);
    rstn = 1'b0;
    #1 chk("err_rst", 64'(err), 64'd0);
    tick();
    rstn = 1'b1;

    // illegal tag 3 is dropped and flags an error
    mem_resp_valid = 1'b1; mem_resp_id = 6'b11_0000; mem_resp_last = 1'b1; resp_ready = 3'b000;
    #1 chk("tag3_rdy", 64'(mem_resp_ready), 64'd1);
    chk("tag3_vld", 64'(resp_valid), 64'b000);
    tick();
    mem_resp_valid = 1'b0; mem_resp_last = 1'b0;
    chk("tag3_err", 64'(err), 64'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("tag3_sticky", 64'(err), 64'd1);
    end
    rstn = 1'b0;
    #1 chk("tag3_rst", 64'(err), 64'd0);
    tick();
    rstn = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_rd_arbiter.md
Name: mem_rd_arbiter

Overview:
- Shares one memory read channel between three read requesters: icache refill (source 0), dcache miss-read (source 1) and dcache uncached read (source 2).
- Grants requests round-robin and tags each downstream ID with its source.
- Caps outstanding transactions per source.
- Routes returned data beats back to the owning requester by ID tag.
- Sits between core_tile's memory ports and the L2/memory model.

Parameters:
- ADDR_W, 40, request address width
- LEN_W, 8, burst length field width (beats minus 1)
- ID_W, 4, per-requester transaction ID width
- DATA_W, 512, response data beat width
- MAX_OUTST, 4, max outstanding transactions per source (1..15)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- req_valid_i  in  3  per-source request valid (bit s = source s)
- req_ready_o  out  3  per-source request accept
- req_addr_i  in  3*ADDR_W  packed per-source addresses, source s at [s*ADDR_W +: ADDR_W]
- req_len_i  in  3*LEN_W  packed per-source burst lengths
- req_id_i  in  3*ID_W  packed per-source IDs
- resp_valid_o  out  3  per-source response beat valid
- resp_ready_i  in  3  per-source response ready
- resp_data_o  out  DATA_W  response data, broadcast to all sources
- resp_id_o  out  ID_W  response ID with source tag stripped
- resp_last_o  out  1  last beat of burst
- mem_req_valid_o  out  1  downstream request valid
- mem_req_ready_i  in  1  downstream request ready
- mem_req_addr_o  out  ADDR_W  downstream address
- mem_req_len_o  out  LEN_W  downstream burst length
- mem_req_id_o  out  ID_W+2  {source[1:0], req_id}
- mem_resp_valid_i  in  1  downstream response valid
- mem_resp_ready_o  out  1  downstream response ready
- mem_resp_data_i  in  DATA_W  downstream response data
- mem_resp_id_i  in  ID_W+2  downstream response ID
- mem_resp_last_i  in  1  downstream last beat
- err_o  out  1  sticky protocol error flag

Behaviour:
Reset values:
- mem_req_valid_o=0, req_ready_o=0, err_o=0.
- Outstanding counters = 0; round-robin pointer = 0, so source 0 has highest priority after reset.
- mem_req_addr_o, mem_req_len_o, mem_req_id_o = 0.

Request path (single output register, FSM EMPTY/FULL):
- Source s is eligible when req_valid_i[s]=1 and cnt[s] < MAX_OUTST.
- The register is loadable when state=EMPTY, or when state=FULL and mem_req_ready_i=1 (same-cycle drain and refill, so throughput is 1 request per cycle).
- When loadable and at least one source is eligible:
  - Pick the first eligible source starting at the RR pointer and wrapping 2->0.
  - Assert req_ready_o for that source only, in the same cycle (combinational).
  - Capture addr, len and {s,id} into the register; state becomes FULL.
  - Set the RR pointer to (s+1) mod 3.
- When state=FULL: mem_req_valid_o=1, and all mem_req_* outputs hold stable until mem_req_ready_i=1.
- When drained with no eligible source: state becomes EMPTY.
- Latency: upstream accept in cycle N, mem_req_valid_o first visible in cycle N+1.

Outstanding counters (one per source, width 4):
- +1 on upstream accept of that source.
- -1 when a response beat with mem_resp_last_i=1 is accepted for that source.
- Increment and decrement in the same cycle leave the counter unchanged.
- A source whose counter equals MAX_OUTST is never granted, even if it holds the highest priority.

Response path (purely combinational, 0 cycles):
- src = mem_resp_id_i[ID_W+1:ID_W].
- For src in 0..2:
  - resp_valid_o[src] = mem_resp_valid_i; all other resp_valid_o bits are 0.
  - mem_resp_ready_o = resp_ready_i[src].
- resp_data_o, resp_id_o (= mem_resp_id_i[ID_W-1:0]) and resp_last_o pass straight through.
- src=3: the beat is dropped (mem_resp_ready_o=1, no resp_valid_o) and err_o is set.
- A last beat for a source whose counter is 0: err_o is set, the counter stays at 0, and the beat is still delivered.
- err_o clears only on reset.

Reset mid-operation:
- A pending register entry is discarded and counters clear.
- Any in-flight responses arriving after reset are the integrator's concern; with counters at 0 their last beats raise err_o.

Test Plan:
- All three sources valid every cycle, mem_req_ready_i=1, MAX_OUTST=4 -> grant order 0,1,2,0 on consecutive cycles; mem_req_id_o tag bits 0,1,2,0; RR pointer = 1 after the 4th grant.
- mem_req_ready_i=0 for 5 cycles with source 1 (addr 0x1000, len 3, id 5) registered -> mem_req_addr_o=0x1000, len=3, id=6'b01_0101 held stable; no req_ready_o pulse until the register drains.
- Source 2 issues 4 requests with no responses -> the 5th request is not accepted (req_ready_o[2]=0) while sources 0 and 1 are still granted; one last beat for source 2 -> the 5th is accepted the next loadable cycle.
- Response burst of 4 beats, id=6'b00_0011, resp_ready_i[0] toggling 1,0,1,1,1 -> resp_valid_o=3'b001 throughout, resp_id_o=3, beats delivered only on ready cycles, cnt[0] decrements once on the last beat.
- Response with tag 3 -> mem_resp_ready_o=1, resp_valid_o=0, err_o=1 and remains 1 until rstn_i is low.
- Assert rstn_i low while FULL with cnt={2,1,3} -> mem_req_valid_o=0 immediately (asynchronously), all counters 0, first post-reset grant goes to source 0.
